instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/soc_cpu_pkg.sv | 18 +
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 tb/tb_instr_fetch_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/soc_cpu_pkg.sv
// soc_cpu_pkg: shared CPU front-end constants and the fetch FSM state encoding.
// Revision 1.0
`default_nettype none

package soc_cpu_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_TRAP  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] c_PC_INCR       = 32'd4;
   localparam logic [31:0] c_PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage : soc_cpu_pkg

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencing and IBus read control with one-cycle delivery latency.
// Optional FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets. Revision 1.0
`default_nettype none

module instr_fetch_unit
   import soc_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_Stall,
   input  logic        i_Redirect,
   input  logic [31:0] i_RedirectPc,
   input  logic        i_IBus_WaitReq,
   output logic [31:0] o_FetchAddr,
   output logic        o_RdEn,
   output logic        o_OZero,
   output logic [31:0] o_InstrPc,
   output logic        o_InstrValid,
   output logic        o_MisalignTrap
);

   fetch_state_e r_State;
   logic [31:0]  r_Pc;
   logic [31:0]  w_Target;
   logic         w_RdEn;
   logic         w_Accepted;
   logic         w_RedirectEn;

   assign w_RdEn       = (r_State == ST_RUN) & ~i_Stall;
   assign w_Accepted   = w_RdEn & ~i_IBus_WaitReq;
   assign w_RedirectEn = i_Redirect & (r_State != ST_RESET);
   assign o_RdEn       = w_RdEn;
   assign o_FetchAddr  = r_Pc;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic w_Misalign;
   logic r_Trap;

   assign w_Target       = i_RedirectPc;
   assign w_Misalign     = |i_RedirectPc[1:0];
   assign o_MisalignTrap = r_Trap;
`else
   // Targets are forced word-aligned, so no trap can ever occur.
   assign w_Target       = i_RedirectPc & c_PC_ALIGN_MASK;
   assign o_MisalignTrap = 1'b0;
`endif

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_State      <= ST_RESET;
         r_Pc         <= RESET_VECTOR;
         o_InstrValid <= 1'b0;
         o_InstrPc    <= RESET_VECTOR;
         o_OZero      <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         r_Trap       <= 1'b0;
`endif
      end else begin
         o_OZero <= w_RdEn & (i_Redirect | i_IBus_WaitReq);
`ifdef FETCH_MISALIGN_TRAP_EN
         r_Trap  <= 1'b0;
`endif
         // While no read is issued the delivered word is held, mirroring the IBus master.
         if (w_RdEn) begin
            o_InstrValid <= w_Accepted & ~i_Redirect;
            o_InstrPc    <= r_Pc;
         end else if (w_RedirectEn) begin
            o_InstrValid <= 1'b0;
         end

         if (w_RedirectEn) begin
            r_Pc <= w_Target;
         end else if (w_Accepted) begin
            r_Pc <= r_Pc + c_PC_INCR;
         end

         case (r_State)
            ST_RESET: r_State <= ST_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_RUN: begin
               if (w_RedirectEn && w_Misalign) begin
                  r_State      <= ST_TRAP;
                  r_Trap       <= 1'b1;
                  o_InstrValid <= 1'b0;
               end
            end
            ST_TRAP: begin
               if (w_RedirectEn && !w_Misalign) begin
                  r_State <= ST_RUN;
               end
            end
`else
            ST_RUN: r_State <= ST_RUN;
`endif
            default: r_State <= ST_RESET;
         endcase
      end
   end

endmodule : instr_fetch_unit

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed per-cycle vectors with a queue-based scoreboard for instr_fetch_unit.
// Revision 1.0
`default_nettype none

module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redir;
   logic [31:0] rpc;
   logic        wr;
   logic [31:0] fetch_addr;
   logic        rd_en;
   logic        ozero;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        trap;

   typedef struct {
      int          idx;
      logic [31:0] addr;
      logic        rden;
      logic        oz;
      logic        iv;
      logic [31:0] ipc;
      logic        trap;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec;
   int   n_miss;
   int   vec_idx;

   instr_fetch_unit dut (
      .i_Clk          (clk),
      .i_Reset        (rst),
      .i_Stall        (stall),
      .i_Redirect     (redir),
      .i_RedirectPc   (rpc),
      .i_IBus_WaitReq (wr),
      .o_FetchAddr    (fetch_addr),
      .o_RdEn         (rd_en),
      .o_OZero        (ozero),
      .o_InstrPc      (instr_pc),
      .o_InstrValid   (instr_valid),
      .o_MisalignTrap (trap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue the outputs expected during that cycle.
   task automatic vec(input logic v_rst, input logic v_stall, input logic v_redir,
                      input logic [31:0] v_rpc, input logic v_wr,
                      input logic [31:0] e_addr, input logic e_rden, input logic e_oz,
                      input logic e_iv, input logic [31:0] e_ipc, input logic e_trap);
      exp_t e;
      #1;
      rst   = v_rst;
      stall = v_stall;
      redir = v_redir;
      rpc   = v_rpc;
      wr    = v_wr;
      e.idx  = vec_idx;
      e.addr = e_addr;
      e.rden = e_rden;
      e.oz   = e_oz;
      e.iv   = e_iv;
      e.ipc  = e_ipc;
      e.trap = e_trap;
      sb_q.push_back(e);
      vec_idx++;
      @(posedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_vec++;
            if (fetch_addr !== e.addr) begin
               n_miss++;
               $display("FAIL v%0d FetchAddr got %h exp %h", e.idx, fetch_addr, e.addr);
            end
            if (rd_en !== e.rden) begin
               n_miss++;
               $display("FAIL v%0d RdEn got %b exp %b", e.idx, rd_en, e.rden);
            end
            if (ozero !== e.oz) begin
               n_miss++;
               $display("FAIL v%0d OZero got %b exp %b", e.idx, ozero, e.oz);
            end
            if (instr_valid !== e.iv) begin
               n_miss++;
               $display("FAIL v%0d InstrValid got %b exp %b", e.idx, instr_valid, e.iv);
            end
            if (instr_pc !== e.ipc) begin
               n_miss++;
               $display("FAIL v%0d InstrPc got %h exp %h", e.idx, instr_pc, e.ipc);
            end
            if (trap !== e.trap) begin
               n_miss++;
               $display("FAIL v%0d MisalignTrap got %b exp %b", e.idx, trap, e.trap);
            end
         end
      end
   end

   initial begin : stimulus
      n_vec   = 0;
      n_miss  = 0;
      vec_idx = 0;
      rst     = 1'b1;
      stall   = 1'b0;
      redir   = 1'b0;
      rpc     = 32'h0;
      wr      = 1'b0;
      repeat (2) @(posedge clk);

      //   rst stall redir rpc           wr  | addr          rden oz iv ipc           trap
      vec(1, 0, 0, 32'h0,         0,  32'h0,         0, 0, 0, 32'h0,         0);
      vec(0, 0, 1, 32'h500,       0,  32'h0,         0, 0, 0, 32'h0,         0);
      vec(0, 0, 0, 32'h0,         0,  32'h0,         1, 0, 0, 32'h0,         0);
      vec(0, 0, 0, 32'h0,         0,  32'h4,         1, 0, 1, 32'h0,         0);
      vec(0, 0, 0, 32'h0,         0,  32'h8,         1, 0, 1, 32'h4,         0);
      vec(0, 0, 0, 32'h0,         0,  32'hC,         1, 0, 1, 32'h8,         0);
      vec(0, 1, 0, 32'h0,         0,  32'h10,        0, 0, 1, 32'hC,         0);
      vec(0, 1, 0, 32'h0,         0,  32'h10,        0, 0, 1, 32'hC,         0);
      vec(0, 0, 0, 32'h0,         0,  32'h10,        1, 0, 1, 32'hC,         0);
      vec(0, 0, 1, 32'h200,       0,  32'h14,        1, 0, 1, 32'h10,        0);
      vec(0, 0, 0, 32'h0,         0,  32'h200,       1, 1, 0, 32'h14,        0);
      vec(0, 0, 1, 32'h1C,        0,  32'h204,       1, 0, 1, 32'h200,       0);
      vec(0, 0, 0, 32'h0,         0,  32'h1C,        1, 1, 0, 32'h204,       0);
      vec(0, 0, 0, 32'h0,         1,  32'h20,        1, 0, 1, 32'h1C,        0);
      vec(0, 0, 0, 32'h0,         0,  32'h20,        1, 1, 0, 32'h20,        0);
      vec(0, 0, 0, 32'h0,         0,  32'h24,        1, 0, 1, 32'h20,        0);
      vec(0, 1, 1, 32'h40,        0,  32'h28,        0, 0, 1, 32'h24,        0);
      vec(0, 1, 0, 32'h0,         0,  32'h40,        0, 0, 0, 32'h24,        0);
      vec(0, 0, 0, 32'h0,         0,  32'h40,        1, 0, 0, 32'h24,        0);
      vec(0, 0, 1, 32'hFFFF_FFF8, 0,  32'h44,        1, 0, 1, 32'h40,        0);
      vec(0, 0, 0, 32'h0,         0,  32'hFFFF_FFF8, 1, 1, 0, 32'h44,        0);
      vec(0, 0, 0, 32'h0,         0,  32'hFFFF_FFFC, 1, 0, 1, 32'hFFFF_FFF8, 0);
      vec(0, 0, 0, 32'h0,         0,  32'h0,         1, 0, 1, 32'hFFFF_FFFC, 0);
      vec(0, 0, 1, 32'h102,       0,  32'h4,         1, 0, 1, 32'h0,         0);
`ifdef FETCH_MISALIGN_TRAP_EN
      vec(0, 0, 0, 32'h0,         0,  32'h102,       0, 1, 0, 32'h4,         1);
      vec(0, 0, 0, 32'h0,         0,  32'h102,       0, 0, 0, 32'h4,         0);
      vec(0, 0, 1, 32'h300,       0,  32'h102,       0, 0, 0, 32'h4,         0);
      vec(0, 0, 0, 32'h0,         0,  32'h300,       1, 0, 0, 32'h4,         0);
`else
      vec(0, 0, 0, 32'h0,         0,  32'h100,       1, 1, 0, 32'h4,         0);
      vec(0, 0, 0, 32'h0,         0,  32'h104,       1, 0, 1, 32'h100,       0);
      vec(0, 0, 1, 32'h300,       0,  32'h108,       1, 0, 1, 32'h104,       0);
      vec(0, 0, 0, 32'h0,         0,  32'h300,       1, 1, 0, 32'h108,       0);
`endif
      vec(0, 0, 0, 32'h0,         0,  32'h304,       1, 0, 1, 32'h300,       0);
      vec(1, 0, 0, 32'h0,         0,  32'h308,       1, 0, 1, 32'h304,       0);
      vec(0, 0, 0, 32'h0,         0,  32'h0,         0, 0, 0, 32'h0,         0);
      vec(0, 0, 0, 32'h0,         0,  32'h0,         1, 0, 0, 32'h0,         0);
      vec(0, 0, 0, 32'h0,         0,  32'h4,         1, 0, 1, 32'h0,         0);

      for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         n_miss++;
         $display("FAIL drain %0d expected entries left unchecked, required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_instr_fetch_unit

`default_nettype wire
